// File: rtl/qpsk_symbol_mod_pkg.sv
// -----------------------------------------------------------------------------
// qpsk_pkg
//
// Shared constants, types and helper functions for the QPSK symbol modulator.
//
// Contents:
//   SAMPLE_W, AMP, SPS  default output width, amplitude magnitude and
//                       samples per symbol
//   sample_t            signed output sample at the default width
//   quadrant_t          2-bit constellation quadrant / phase index
//   sign_pair_t         per-axis "negative" flags for one constellation point
//   dibit_to_quadrant() Gray-coded dibit to quadrant increment
//   quadrant_signs()    quadrant to (I,Q) sign table
//
// Optional feature macro used by the files that import this package:
//   QPSK_DIFF_EN  differential (DQPSK) encoding
// -----------------------------------------------------------------------------
package qpsk_pkg;

    localparam int SAMPLE_W = 12;
    localparam int AMP      = 1448;  // about 0.707 * 2047
    localparam int SPS      = 4;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [1:0]                 quadrant_t;

    // A set flag selects -AMP on that axis, a clear flag selects +AMP.
    typedef struct packed {
        logic i_neg;
        logic q_neg;
    } sign_pair_t;

    // Gray-coded phase increment, dibit written as {I,Q}:
    //   00 -> 0, 01 -> 1, 11 -> 2, 10 -> 3
    // This is {I, I^Q}, which walks the Gray sequence in order.
    function automatic quadrant_t dibit_to_quadrant(input logic bit_i, input logic bit_q);
        return {bit_i, bit_i ^ bit_q};
    endfunction

    // Constellation point for each quadrant:
    //   0 -> (+,+), 1 -> (-,+), 2 -> (-,-), 3 -> (+,-)
    function automatic sign_pair_t quadrant_signs(input quadrant_t quad);
        sign_pair_t signs;
        signs.i_neg = quad[1] ^ quad[0];
        signs.q_neg = quad[1];
        return signs;
    endfunction

endpackage : qpsk_pkg

// File: rtl/qpsk_symbol_mod_if.sv
// -----------------------------------------------------------------------------
// qpsk_symbol_mod_if
//
// Bundles the two streams of the QPSK modulator: the dibit input handshake
// and the sample output handshake.
//
// Signals:
//   i_I, i_Q            in-phase / quadrature data bits
//   i_valid             input dibit valid
//   o_ready_for_input   modulator can take a dibit this cycle
//   o_valid             output sample valid
//   i_out_ready         downstream ready for a sample
//   o_I, o_Q            signed output samples
//
// Modports:
//   slave   the modulator itself
//   master  the surrounding environment (bit source + DAC-side sink)
// -----------------------------------------------------------------------------
interface qpsk_symbol_mod_if #(
    parameter int SAMPLE_W = qpsk_pkg::SAMPLE_W
);

    logic                       i_I;
    logic                       i_Q;
    logic                       i_valid;
    logic                       o_ready_for_input;

    logic                       o_valid;
    logic                       i_out_ready;
    logic signed [SAMPLE_W-1:0] o_I;
    logic signed [SAMPLE_W-1:0] o_Q;

    modport slave (
        input  i_I,
        input  i_Q,
        input  i_valid,
        input  i_out_ready,
        output o_ready_for_input,
        output o_valid,
        output o_I,
        output o_Q
    );

    modport master (
        output i_I,
        output i_Q,
        output i_valid,
        output i_out_ready,
        input  o_ready_for_input,
        input  o_valid,
        input  o_I,
        input  o_Q
    );

endinterface : qpsk_symbol_mod_if

// File: rtl/qpsk_symbol_mod_mapper.sv
// -----------------------------------------------------------------------------
// qpsk_mapper
//
// Purely combinational symbol mapper: one dibit in, one (I,Q) sample pair out.
//
// Default build: direct Gray mapping per axis, bit 0 -> +AMP, bit 1 -> -AMP.
// With QPSK_DIFF_EN defined: the dibit advances the current phase quadrant
// by a Gray increment, and the new quadrant selects the constellation point.
// The advanced quadrant is returned so the caller can register it.
//
// Ports:
//   bit_i_i, bit_q_i        dibit to map
//   phase_i                 current phase quadrant      (QPSK_DIFF_EN only)
//   phase_o                 advanced phase quadrant     (QPSK_DIFF_EN only)
//   sample_i_o, sample_q_o  signed amplitudes
// -----------------------------------------------------------------------------
module qpsk_mapper
    import qpsk_pkg::*;
#(
    parameter int SAMPLE_W = qpsk_pkg::SAMPLE_W,
    parameter int AMP      = qpsk_pkg::AMP
) (
    input  logic                       bit_i_i,
    input  logic                       bit_q_i,
`ifdef QPSK_DIFF_EN
    input  quadrant_t                  phase_i,
    output quadrant_t                  phase_o,
`endif
    output logic signed [SAMPLE_W-1:0] sample_i_o,
    output logic signed [SAMPLE_W-1:0] sample_q_o
);

    localparam logic signed [SAMPLE_W-1:0] POS_AMP = SAMPLE_W'(AMP);
    localparam logic signed [SAMPLE_W-1:0] NEG_AMP = SAMPLE_W'(-AMP);

    sign_pair_t signs;

`ifdef QPSK_DIFF_EN
    // Quadrant arithmetic wraps naturally in 2 bits (mod 4).
    assign phase_o = phase_i + dibit_to_quadrant(bit_i_i, bit_q_i);
    assign signs   = quadrant_signs(phase_o);
`else
    assign signs = '{i_neg: bit_i_i, q_neg: bit_q_i};
`endif

    assign sample_i_o = signs.i_neg ? NEG_AMP : POS_AMP;
    assign sample_q_o = signs.q_neg ? NEG_AMP : POS_AMP;

endmodule : qpsk_mapper

// File: rtl/qpsk_symbol_mod.sv
// -----------------------------------------------------------------------------
// qpsk_symbol_mod
//
// Baseband QPSK modulator. Takes one dibit per input handshake, maps it to a
// signed (+/-AMP, +/-AMP) pair and emits it as SPS identical samples
// (rectangular pulse) on a valid/ready output stream. A new symbol can be
// accepted on the same edge as the last sample of the previous one, so a
// continuously fed modulator produces samples with no bubbles.
//
// Parameters:
//   SAMPLE_W  output sample width (signed)
//   AMP       amplitude magnitude, 0 < AMP < 2**(SAMPLE_W-1)
//   SPS       output samples per symbol, >= 1
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   qpsk_symbol_mod_if.slave: dibit input and sample output streams
//
// Optional feature macro:
//   QPSK_DIFF_EN  differential (DQPSK) encoding with a 2-bit phase register
// -----------------------------------------------------------------------------
module qpsk_symbol_mod
    import qpsk_pkg::*;
#(
    parameter int SAMPLE_W = qpsk_pkg::SAMPLE_W,
    parameter int AMP      = qpsk_pkg::AMP,
    parameter int SPS      = qpsk_pkg::SPS
) (
    input logic              clk,
    input logic              rst,
    qpsk_symbol_mod_if.slave bus
);

    // A 1-bit counter is kept even for SPS == 1 so the logic has no
    // zero-width vectors; it then simply stays at 0.
    localparam int              CNT_W    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                       valid_q,  valid_d;
    logic signed [SAMPLE_W-1:0] samp_i_q, samp_i_d;
    logic signed [SAMPLE_W-1:0] samp_q_q, samp_q_d;
    logic [CNT_W-1:0]           cnt_q,    cnt_d;
`ifdef QPSK_DIFF_EN
    quadrant_t                  phase_q,  phase_d;
    quadrant_t                  phase_next;
`endif

    // -------------------------------------------------------------------------
    // Mapper
    // -------------------------------------------------------------------------
    logic signed [SAMPLE_W-1:0] map_i;
    logic signed [SAMPLE_W-1:0] map_q;

    qpsk_mapper #(
        .SAMPLE_W (SAMPLE_W),
        .AMP      (AMP)
    ) u_mapper (
        .bit_i_i    (bus.i_I),
        .bit_q_i    (bus.i_Q),
`ifdef QPSK_DIFF_EN
        .phase_i    (phase_q),
        .phase_o    (phase_next),
`endif
        .sample_i_o (map_i),
        .sample_q_o (map_q)
    );

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic xfer;       // an output sample transfers at this edge
    logic last_xfer;  // ...and it is the final sample of the symbol
    logic ready;
    logic accept;

    assign xfer      = valid_q && bus.i_out_ready;
    assign last_xfer = xfer && (cnt_q == CNT_LAST);

    // Ready depends only on registered state, rst and i_out_ready, never on
    // i_valid, so there is no combinational loop through the source.
    assign ready  = !rst && (!valid_q || last_xfer);
    assign accept = bus.i_valid && ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every _d signal gets its hold value first, so no path through the
    // block leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d  = valid_q;
        samp_i_d = samp_i_q;
        samp_q_d = samp_q_q;
        cnt_d    = cnt_q;
`ifdef QPSK_DIFF_EN
        phase_d  = phase_q;
`endif

        if (accept) begin
            // New symbol, either from idle or back-to-back on the last sample.
            valid_d  = 1'b1;
            samp_i_d = map_i;
            samp_q_d = map_q;
            cnt_d    = '0;
`ifdef QPSK_DIFF_EN
            phase_d  = phase_next;
`endif
        end else if (last_xfer) begin
            // Symbol finished with nothing queued: return to idle, zero output.
            valid_d  = 1'b0;
            samp_i_d = '0;
            samp_q_d = '0;
            cnt_d    = '0;
        end else if (xfer) begin
            cnt_d    = cnt_q + CNT_W'(1);
        end
        // With o_valid && !i_out_ready nothing changes: outputs and count hold.
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            samp_i_q <= '0;
            samp_q_q <= '0;
            cnt_q    <= '0;
`ifdef QPSK_DIFF_EN
            phase_q  <= '0;
`endif
        end else begin
            valid_q  <= valid_d;
            samp_i_q <= samp_i_d;
            samp_q_q <= samp_q_d;
            cnt_q    <= cnt_d;
`ifdef QPSK_DIFF_EN
            phase_q  <= phase_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.o_ready_for_input = ready;
    assign bus.o_valid           = valid_q;
    assign bus.o_I               = samp_i_q;
    assign bus.o_Q               = samp_q_q;

endmodule : qpsk_symbol_mod

// File: tb/tb_qpsk_symbol_mod.sv
// -----------------------------------------------------------------------------
// tb_qpsk_symbol_mod
//
// Directed bench for qpsk_symbol_mod with SAMPLE_W=12, AMP=1448, SPS=4.
// +AMP = 12'h5A8, -AMP = 12'hA58. With QPSK_DIFF_EN defined the expected
// constellation points follow the differential phase walk instead of the
// direct per-axis mapping, and an extra DQPSK sequence is run at the end.
// -----------------------------------------------------------------------------
module tb_qpsk_symbol_mod;

    localparam int         SW   = 12;
    localparam int         AMPL = 1448;
    localparam int         SPSL = 4;
    localparam logic [11:0] P   = 12'h5A8;
    localparam logic [11:0] N   = 12'hA58;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    qpsk_symbol_mod_if #(.SAMPLE_W(SW)) bus ();

    qpsk_symbol_mod #(
        .SAMPLE_W (SW),
        .AMP      (AMPL),
        .SPS      (SPSL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] tb_phase = 2'd0;

    logic [7:0] str_i = 8'b1111_0100;  // stream I bits, symbol 0 at bit 0
    logic [7:0] str_q = 8'b1100_1110;  // stream Q bits, symbol 0 at bit 0

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {I,Q} for the next accepted dibit; tracks phase in DQPSK builds.
    function automatic logic [23:0] expected(input logic bi, input logic bq);
`ifdef QPSK_DIFF_EN
        logic [1:0] inc;
        case ({bi, bq})
            2'b00:   inc = 2'd0;
            2'b01:   inc = 2'd1;
            2'b11:   inc = 2'd2;
            default: inc = 2'd3;
        endcase
        tb_phase = tb_phase + inc;
        case (tb_phase)
            2'd0:    return {P, P};
            2'd1:    return {N, P};
            2'd2:    return {N, N};
            default: return {P, N};
        endcase
`else
        return {(bi ? N : P), (bq ? N : P)};
`endif
    endfunction

    task automatic check_sample(input string tag, input logic [23:0] e);
        chk({tag, ".valid"}, {31'd0, bus.o_valid}, 32'd1);
        chk({tag, ".I"},     {20'd0, bus.o_I},     {20'd0, e[23:12]});
        chk({tag, ".Q"},     {20'd0, bus.o_Q},     {20'd0, e[11:0]});
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".valid"}, {31'd0, bus.o_valid}, 32'd0);
        chk({tag, ".I"},     {20'd0, bus.o_I},     32'd0);
        chk({tag, ".Q"},     {20'd0, bus.o_Q},     32'd0);
    endtask

    // One isolated symbol with i_out_ready held high, then idle check.
    task automatic send_one(input string tag, input logic bi, input logic bq,
                            input logic [23:0] e);
        chk({tag, ".rdy_idle"}, {31'd0, bus.o_ready_for_input}, 32'd1);
        bus.i_I = bi;
        bus.i_Q = bq;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        bus.i_I = ~bi;  // must be ignored now
        bus.i_Q = ~bq;
        for (int k = 0; k < SPSL; k++) begin
            check_sample($sformatf("%s.s%0d", tag, k), e);
            chk($sformatf("%s.rdy%0d", tag, k), {31'd0, bus.o_ready_for_input},
                (k == SPSL - 1) ? 32'd1 : 32'd0);
            tick();
        end
        check_idle({tag, ".end"});
    endtask

    initial begin
        logic [23:0] e;

        // ---------------- 1. reset ----------------
        rst = 1'b1;
        bus.i_I = 1'b0;
        bus.i_Q = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_out_ready = 1'b0;
        tick();
        tick();
        check_idle("rst");
        chk("rst.rdy", {31'd0, bus.o_ready_for_input}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel.rdy", {31'd0, bus.o_ready_for_input}, 32'd1);
        bus.i_out_ready = 1'b1;

        // ---------------- 2. mapping + 5. idle gap ----------------
        e = expected(1'b0, 1'b0);
        send_one("map00", 1'b0, 1'b0, e);
        e = expected(1'b1, 1'b1);
        send_one("map11", 1'b1, 1'b1, e);
        e = expected(1'b0, 1'b1);
        send_one("map01", 1'b0, 1'b1, e);

        // ---------------- 3. back-to-back streaming ----------------
        bus.i_I = str_i[0];
        bus.i_Q = str_q[0];
        bus.i_valid = 1'b1;
        chk("str.rdy_start", {31'd0, bus.o_ready_for_input}, 32'd1);
        tick();
        for (int s = 0; s < 8; s++) begin
            e = expected(str_i[s], str_q[s]);
            if (s < 7) begin
                bus.i_I = str_i[s+1];
                bus.i_Q = str_q[s+1];
            end else begin
                bus.i_valid = 1'b0;
            end
            for (int k = 0; k < SPSL; k++) begin
                check_sample($sformatf("str%0d.s%0d", s, k), e);
                chk($sformatf("str%0d.rdy%0d", s, k), {31'd0, bus.o_ready_for_input},
                    (k == SPSL - 1) ? 32'd1 : 32'd0);
                tick();
            end
        end
        check_idle("str.end");

        // ---------------- 4. backpressure ----------------
        bus.i_I = 1'b1;
        bus.i_Q = 1'b0;
        bus.i_valid = 1'b1;
        tick();
        e = expected(1'b1, 1'b0);
        bus.i_I = 1'b0;   // pending dibit that must not be taken mid-symbol
        bus.i_Q = 1'b1;
        check_sample("bp.s0", e);
        tick();
        bus.i_out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_sample($sformatf("bp.stall%0d", c), e);
            chk($sformatf("bp.stall%0d.rdy", c), {31'd0, bus.o_ready_for_input}, 32'd0);
        end
        bus.i_out_ready = 1'b1;
        bus.i_valid = 1'b0;
        for (int k = 1; k < SPSL; k++) begin
            check_sample($sformatf("bp.s%0d", k), e);
            tick();
        end
        check_idle("bp.end");

        // ---------------- reset mid-symbol ----------------
        bus.i_I = 1'b0;
        bus.i_Q = 1'b1;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        e = expected(1'b0, 1'b1);
        tick();
        check_sample("mid.s1", e);
        rst = 1'b1;
        tick();
        check_idle("mid.rst");
        chk("mid.rst.rdy", {31'd0, bus.o_ready_for_input}, 32'd0);
        rst = 1'b0;
        tb_phase = 2'd0;
        #1;

`ifdef QPSK_DIFF_EN
        // ---------------- 6. DQPSK walk from reset ----------------
        send_one("dq00", 1'b0, 1'b0, {P, P});
        send_one("dq01", 1'b0, 1'b1, {N, P});
        send_one("dq11", 1'b1, 1'b1, {P, N});
        send_one("dq10", 1'b1, 1'b0, {N, N});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_qpsk_symbol_mod
